gpu_pixel_writer: RTL and testbench

- Consumer end of the shape-generator pixel stream (fill circle, line, rectangle units).
- Samples streamed X/Y coordinates and colour each cycle and drops off-screen or sentinel points.
- Converts accepted points to linear framebuffer addresses, buffers them in a small FIFO, and drains them to the SRAM/framebuffer controller over a req/ack write handshake.
- Reports drain completion back to the GPU command sequencer.

---
 rtl/gpu_pixel_writer.sv | 212 +++++++++++++++++++++
 tb/tb_gpu_pixel_writer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_pixel_writer.sv
// gpu_pixel_writer: consumer end of the shape-generator pixel stream.
// Samples X/Y/colour while the generator is busy, drops off-screen and
// sentinel points, converts accepted points to linear framebuffer addresses,
// queues them in a small FIFO and drains them over a req/ack write handshake.
// Optional build macro: GPU_PIXEL_DEDUP_EN (drop repeats of the last pixel).
// Ports:
//   clk, n_rst                     clock, async active-low reset
//   X_i, Y_i, r_i, g_i, b_i        generator pixel coordinate and colour
//   gen_busy_i, gen_done_i         generator job status
//   mem_ack_i                      memory accepted the current write
//   mem_wr_o, mem_addr_o, mem_data_o  write request, Y*WIDTH+X, {r,g,b}
//   busy_o, done_o, overflow_o     job busy, drain-complete pulse, sticky drop
module gpu_pixel_writer #(
  parameter int unsigned WIDTH        = 640,
  parameter int unsigned HEIGHT       = 480,
  parameter int unsigned CHANNEL_BITS = 4,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned ADDR_BITS    = 19,
  localparam int unsigned WIDTH_BITS  = $clog2(WIDTH + 1),
  localparam int unsigned HEIGHT_BITS = $clog2(HEIGHT + 1)
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [WIDTH_BITS-1:0]     X_i,
  input  logic [HEIGHT_BITS-1:0]    Y_i,
  input  logic [CHANNEL_BITS-1:0]   r_i,
  input  logic [CHANNEL_BITS-1:0]   g_i,
  input  logic [CHANNEL_BITS-1:0]   b_i,
  input  logic                      gen_busy_i,
  input  logic                      gen_done_i,
  input  logic                      mem_ack_i,
  output logic                      mem_wr_o,
  output logic [ADDR_BITS-1:0]      mem_addr_o,
  output logic [3*CHANNEL_BITS-1:0] mem_data_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      overflow_o
);

  localparam int unsigned PTR_BITS   = $clog2(FIFO_DEPTH);
  localparam int unsigned DATA_BITS  = 3 * CHANNEL_BITS;
  localparam int unsigned ENTRY_BITS = ADDR_BITS + DATA_BITS;
  localparam logic [WIDTH_BITS-1:0]  X_LIMIT = WIDTH_BITS'(WIDTH);
  localparam logic [HEIGHT_BITS-1:0] Y_LIMIT = HEIGHT_BITS'(HEIGHT);

  typedef enum logic {S_IDLE = 1'b0, S_WRITE = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic                   gen_busy_q;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   overflow_q, overflow_d;
  logic                   done_pend_q, done_pend_d;
  logic                   mem_wr_q, mem_wr_d;
  logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_BITS-1:0]   mem_data_q, mem_data_d;
  logic [PTR_BITS:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS:0]      rd_ptr_q, rd_ptr_d;
  logic [ENTRY_BITS-1:0]  fifo_mem_q [FIFO_DEPTH];

  logic                   job_start_c, valid_c, dup_c, accept_c;
  logic                   push_c, pop_c, fifo_empty_c, fifo_full_c;
  logic [ENTRY_BITS-1:0]  entry_c, head_c;

  // Sample qualification and address formation
  assign job_start_c = gen_busy_i & ~gen_busy_q;
  assign valid_c     = gen_busy_i && (X_i < X_LIMIT) && (Y_i < Y_LIMIT);
  assign accept_c    = valid_c & ~dup_c;
  assign entry_c     = {ADDR_BITS'(Y_i) * ADDR_BITS'(WIDTH) + ADDR_BITS'(X_i),
                        r_i, g_i, b_i};

`ifdef GPU_PIXEL_DEDUP_EN
  logic [WIDTH_BITS-1:0]  last_x_q, last_x_d, last_x_ref_c;
  logic [HEIGHT_BITS-1:0] last_y_q, last_y_d, last_y_ref_c;

  // A job's first sample is compared against the sentinel, not the old job's tail
  always_comb begin
    last_x_ref_c = job_start_c ? X_LIMIT : last_x_q;
    last_y_ref_c = job_start_c ? Y_LIMIT : last_y_q;
    dup_c        = (X_i == last_x_ref_c) && (Y_i == last_y_ref_c);
    last_x_d     = last_x_ref_c;
    last_y_d     = last_y_ref_c;
    if (valid_c && !dup_c) begin
      last_x_d = X_i;
      last_y_d = Y_i;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      last_x_q <= X_LIMIT;
      last_y_q <= Y_LIMIT;
    end else begin
      last_x_q <= last_x_d;
      last_y_q <= last_y_d;
    end
  end
`else
  assign dup_c = 1'b0;
`endif

  // FIFO bookkeeping; a full FIFO still accepts when the same cycle pops
  assign fifo_empty_c = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_c  = (wr_ptr_q[PTR_BITS] != rd_ptr_q[PTR_BITS]) &&
                        (wr_ptr_q[PTR_BITS-1:0] == rd_ptr_q[PTR_BITS-1:0]);
  assign head_c       = fifo_mem_q[rd_ptr_q[PTR_BITS-1:0]];
  assign push_c       = accept_c & (~fifo_full_c | pop_c);
  assign wr_ptr_d     = wr_ptr_q + (PTR_BITS+1)'(push_c);
  assign rd_ptr_d     = rd_ptr_q + (PTR_BITS+1)'(pop_c);

  always_ff @(posedge clk) begin
    if (push_c) fifo_mem_q[wr_ptr_q[PTR_BITS-1:0]] <= entry_c;
  end

  // Write FSM: state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Write FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty_c) state_d = S_WRITE;
      S_WRITE: if (mem_ack_i && fifo_empty_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Write FSM: outputs and pop
  always_comb begin
    pop_c      = 1'b0;
    mem_wr_d   = mem_wr_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_c) begin
          pop_c = 1'b1;
          mem_wr_d = 1'b1;
          {mem_addr_d, mem_data_d} = head_c;
        end
      end
      S_WRITE: begin
        if (mem_ack_i) begin
          if (!fifo_empty_c) begin
            pop_c = 1'b1;
            {mem_addr_d, mem_data_d} = head_c;
          end else begin
            mem_wr_d = 1'b0;
          end
        end
      end
      default: mem_wr_d = 1'b0;
    endcase
  end

  // Job status: completion first, job start overrides, done request last
  always_comb begin
    busy_d      = busy_q;
    done_d      = 1'b0;
    overflow_d  = overflow_q;
    done_pend_d = done_pend_q;
    if (done_pend_q && fifo_empty_c && (state_q == S_IDLE) && !mem_wr_q) begin
      done_d      = 1'b1;
      busy_d      = 1'b0;
      done_pend_d = 1'b0;
    end
    if (job_start_c) begin
      busy_d      = 1'b1;
      overflow_d  = 1'b0;
      done_pend_d = 1'b0;
    end
    if (gen_done_i) done_pend_d = 1'b1;
    if (accept_c && fifo_full_c && !pop_c) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      gen_busy_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      done_pend_q <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      gen_busy_q  <= gen_busy_i;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      done_pend_q <= done_pend_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  assign mem_wr_o   = mem_wr_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_gpu_pixel_writer.sv
// Self-checking bench for gpu_pixel_writer (640x480, 4-bit channels, depth 8).
// A queue-based reference model predicts writes, status and overflow.
module tb_gpu_pixel_writer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [3:0]  r, g, b;
  logic        gen_busy, gen_done, ack;
  logic        mem_wr_o, busy_o, done_o, overflow_o;
  logic [18:0] mem_addr_o;
  logic [11:0] mem_data_o;

  gpu_pixel_writer #(
    .WIDTH(640), .HEIGHT(480), .CHANNEL_BITS(4), .FIFO_DEPTH(DEPTH), .ADDR_BITS(19)
  ) dut (
    .clk(clk), .n_rst(n_rst), .X_i(x), .Y_i(y), .r_i(r), .g_i(g), .b_i(b),
    .gen_busy_i(gen_busy), .gen_done_i(gen_done), .mem_ack_i(ack),
    .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [30:0] m_q[$];
  logic        m_wr, m_busy, m_done, m_ovf, m_pend, m_prev;
  logic [18:0] m_addr;
  logic [11:0] m_data;
  int          m_lx, m_ly;
  int          dut_writes, dut_3205;

  task automatic model_reset();
    m_q.delete();
    m_wr = 0; m_busy = 0; m_done = 0; m_ovf = 0; m_pend = 0; m_prev = 0;
    m_addr = '0; m_data = '0;
    m_lx = 640; m_ly = 480;
  endtask

  // Advance the model by one clock using the inputs currently driven
  task automatic step();
    bit start, pop, valid, dup, acc, drained;
    int xi, yi, lx, ly;
    xi = int'(x); yi = int'(y);
    if (mem_wr_o && ack) begin
      dut_writes++;
      if (mem_addr_o == 19'd3205) dut_3205++;
    end
    start   = gen_busy && !m_prev;
    pop     = (m_q.size() > 0) && (!m_wr || ack);
    valid   = gen_busy && xi < 640 && yi < 480;
    lx = start ? 640 : m_lx;
    ly = start ? 480 : m_ly;
`ifdef GPU_PIXEL_DEDUP_EN
    dup = valid && xi == lx && yi == ly;
    if (valid && !dup) begin lx = xi; ly = yi; end
`else
    dup = 0;
`endif
    m_lx = lx; m_ly = ly;
    acc     = valid && !dup;
    drained = m_pend && m_q.size() == 0 && !m_wr;
    m_done  = drained;
    if (drained) begin m_busy = 0; m_pend = 0; end
    if (start) begin m_busy = 1; m_ovf = 0; m_pend = 0; end
    if (gen_done) m_pend = 1;
    if (pop) begin
      m_wr = 1;
      {m_addr, m_data} = m_q.pop_front();
    end else if (ack) begin
      m_wr = 0;
    end
    if (acc) begin
      if (m_q.size() < DEPTH) m_q.push_back({19'(yi * 640 + xi), r, g, b});
      else m_ovf = 1;
    end
    m_prev = gen_busy;
  endtask

  task automatic compare();
    chk("mem_wr", 32'(mem_wr_o), 32'(m_wr));
    chk("busy", 32'(busy_o), 32'(m_busy));
    chk("done", 32'(done_o), 32'(m_done));
    chk("overflow", 32'(overflow_o), 32'(m_ovf));
    if (m_wr) begin
      chk("mem_addr", 32'(mem_addr_o), 32'(m_addr));
      chk("mem_data", 32'(mem_data_o), 32'(m_data));
    end
  endtask

  // Drive one cycle of inputs at the falling edge, check after the next rise
  task automatic tick(input logic bz, input int xi, input int yi,
                      input logic [11:0] rgb, input logic dn, input logic ak);
    gen_busy = bz; x = 10'(xi); y = 9'(yi); {r, g, b} = rgb;
    gen_done = dn; ack = ak;
    step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n, input logic ak);
    for (int i = 0; i < n; i++) tick(1'b0, 640, 480, 12'h0, 1'b0, ak);
  endtask

  logic rec_wr[24];
  logic rec_dn[24];
  logic rec_bz[24];

  initial begin
    int w0, s, run;
    n_rst = 1'b0;
    gen_busy = 0; gen_done = 0; ack = 0; x = '0; y = '0; {r, g, b} = '0;
    dut_writes = 0; dut_3205 = 0;
    model_reset();
    #1;
    chk("reset_wr", 32'(mem_wr_o), 0);
    chk("reset_busy", 32'(busy_o), 0);
    @(negedge clk); @(negedge clk);
    n_rst = 1'b1;
    idle(2, 1'b0);

    // Single pixel with delayed ack
    tick(1'b1, 10, 2, 12'hF0A, 1'b0, 1'b0);
    tick(1'b1, 640, 480, 12'h0, 1'b0, 1'b0);
    chk("t1_wr_rise", 32'(mem_wr_o), 1);
    for (int i = 0; i < 3; i++) begin
      chk("t1_addr", 32'(mem_addr_o), 1290);
      chk("t1_data", 32'(mem_data_o), 32'h0F0A);
      tick(1'b1, 640, 480, 12'h0, 1'b0, 1'b0);
    end
    chk("t1_hold", 32'(mem_wr_o), 1);
    tick(1'b1, 640, 480, 12'h0, 1'b0, 1'b1);
    chk("t1_wr_fall", 32'(mem_wr_o), 0);
    tick(1'b0, 640, 480, 12'h0, 1'b1, 1'b0);
    idle(3, 1'b0);

    // Off-screen and sentinel samples produce no write
    w0 = dut_writes;
    tick(1'b1, 640, 480, 12'h111, 1'b0, 1'b1);
    tick(1'b1, 1023, 5, 12'h222, 1'b0, 1'b1);
    tick(1'b1, 5, 480, 12'h333, 1'b0, 1'b1);
    tick(1'b0, 640, 480, 12'h0, 1'b1, 1'b1);
    tick(1'b0, 640, 480, 12'h0, 1'b0, 1'b1);
    chk("t2_done", 32'(done_o), 1);
    idle(3, 1'b1);
    chk("t2_no_write", 32'(dut_writes - w0), 0);

    // Parked pixel with ack tied high
    dut_3205 = 0;
    for (int i = 0; i < 4; i++) tick(1'b1, 5, 5, 12'h5A5, 1'b0, 1'b1);
    tick(1'b0, 640, 480, 12'h0, 1'b1, 1'b1);
    idle(8, 1'b1);
`ifdef GPU_PIXEL_DEDUP_EN
    chk("t3_writes_3205", 32'(dut_3205), 1);
`else
    chk("t3_writes_3205", 32'(dut_3205), 4);
`endif

    // Overflow: ack low, ten distinct pixels
    for (int i = 1; i <= 10; i++) tick(1'b1, i * 3, 7, 12'(i), 1'b0, 1'b0);
    chk("t4_overflow", 32'(overflow_o), 1);
    w0 = dut_writes;
    tick(1'b0, 640, 480, 12'h0, 1'b1, 1'b1);
    idle(14, 1'b1);
    chk("t4_writes", 32'(dut_writes - w0), 9);
    chk("t4_ovf_sticky", 32'(overflow_o), 1);
    tick(1'b1, 640, 480, 12'h0, 1'b0, 1'b1);
    chk("t4_ovf_clear", 32'(overflow_o), 0);
    tick(1'b0, 640, 480, 12'h0, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Three back-to-back writes, done on the last pixel
    for (int i = 0; i < 24; i++) begin
      if (i < 3) tick(1'b1, 100 + i, 50, 12'hA00 + 12'(i), i == 2, 1'b1);
      else       tick(1'b0, 640, 480, 12'h0, 1'b0, 1'b1);
      rec_wr[i] = mem_wr_o; rec_dn[i] = done_o; rec_bz[i] = busy_o;
    end
    s = -1; run = 0;
    for (int i = 0; i < 20; i++) begin
      if (s < 0 && rec_wr[i]) s = i;
    end
    if (s >= 0) begin
      for (int i = s; i < 20 && rec_wr[i]; i++) run++;
    end
    chk("t5_run", 32'(run), 3);
    if (s >= 0) begin
      chk("t5_done_after_fall", 32'(rec_dn[s + run + 1]), 1);
      chk("t5_busy_after_fall", 32'(rec_bz[s + run + 1]), 0);
      chk("t5_no_early_done", 32'(rec_dn[s + run]), 0);
    end

    // Async reset while a write is outstanding
    tick(1'b1, 33, 44, 12'h123, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("t6_wr_before", 32'(mem_wr_o), 1);
    #2 n_rst = 1'b0;
    #1;
    chk("t6_rst_wr", 32'(mem_wr_o), 0);
    chk("t6_rst_busy", 32'(busy_o), 0);
    chk("t6_rst_ovf", 32'(overflow_o), 0);
    chk("t6_rst_done", 32'(done_o), 0);
    model_reset();
    @(negedge clk);
    n_rst = 1'b1;
    w0 = dut_writes;
    idle(5, 1'b1);
    chk("t6_no_write", 32'(dut_writes - w0), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic bz, dn, ak;
      int xi, yi, sel;
      bz  = ($urandom_range(0, 15) != 0) ? gen_busy : ~gen_busy;
      dn  = ($urandom_range(0, 39) == 0);
      ak  = ($urandom_range(0, 1) == 1);
      sel = $urandom_range(0, 9);
      if (sel < 6)      begin xi = $urandom_range(0, 3);   yi = $urandom_range(0, 2);   end
      else if (sel < 8) begin xi = $urandom_range(0, 639); yi = $urandom_range(0, 479); end
      else              begin xi = $urandom_range(0, 1023); yi = $urandom_range(0, 511); end
      tick(bz, xi, yi, 12'($urandom), dn, ak);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
